// File: rtl/pipeline_elastic_buffer_if.sv
// Valid/ready stream bundle for pipeline_elastic_buffer. Signal directions are named from the
// buffer's point of view: *_in flows into the buffer and *_out flows out of it.
interface pipeline_elastic_buffer_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             valid_in;
  logic [WIDTH-1:0] data_in;
  logic             ready_out;
  logic             valid_out;
  logic [WIDTH-1:0] data_out;
  logic             ready_in;

  // Environment side: the upstream producer and the downstream consumer together.
  modport master (
    output valid_in, data_in, ready_in,
    input  ready_out, valid_out, data_out
  );

  // Buffer side.
  modport slave (
    input  valid_in, data_in, ready_in,
    output ready_out, valid_out, data_out
  );
endinterface

// File: rtl/pipeline_elastic_buffer.sv
// DEPTH-entry elastic FIFO on a valid/ready stream. It reports occupancy on count.
// Defining PIPE_EB_FLUSH_EN adds a flush input that empties the buffer.
module pipeline_elastic_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef PIPE_EB_FLUSH_EN
  input  logic                    flush,
`endif
  pipeline_elastic_buffer_if.slave stream,
  output logic [CW-1:0]           count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop, clear;

  // The handshake outputs depend on registered state only. This keeps the ready and data
  // paths between the two sides registered.
  assign stream.ready_out = (count_q != CountFull) & ~rst;
  assign stream.valid_out = (count_q != '0);
  assign stream.data_out  = stream.valid_out ? mem_q[rd_ptr_q] : '0;
  assign count            = count_q;

`ifdef PIPE_EB_FLUSH_EN
  assign clear = flush;
`else
  assign clear = 1'b0;
`endif

  assign push = stream.valid_in & stream.ready_out & ~clear;
  assign pop  = stream.valid_out & stream.ready_in & ~clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset. push is already gated by rst through ready_out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= stream.data_in;
    end
  end

endmodule
